noc_pe_inject_arbiter: RTL and testbench

// Local-side injection scheduler for one NoC switch node. Round-robin arbitrates N_REQ local

---
 rtl/noc_pe_inject_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_noc_pe_inject_arbiter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/noc_pe_inject_arbiter.sv
// Local injection scheduler for one NoC switch node.
// Round-robin picks one of N_REQ local requesters, registers its flit with the
// routing header {dest_y,dest_x} in the low bits, and presents it to the
// switch PE port. The flit stays bit-stable while the switch refuses it.
// The block also counts refused cycles (starvation flag) and accepted flits.
module noc_pe_inject_arbiter #(
  parameter int N_REQ        = 4,
  parameter int data_width   = 256,
  parameter int x_size       = 1,
  parameter int y_size       = 1,
  parameter int total_width  = x_size + y_size + data_width,
  parameter int STARVE_LIMIT = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            i_valid_req,
  output logic [N_REQ-1:0]            o_ready_req,
  input  logic [N_REQ*data_width-1:0] i_data_req,
  input  logic [N_REQ*x_size-1:0]     i_dest_x,
  input  logic [N_REQ*y_size-1:0]     i_dest_y,
  output logic                        o_valid_pe,
  output logic [total_width-1:0]      o_data_pe,
  input  logic                        i_ready_pe,
  output logic                        o_starve,
  output logic [15:0]                 o_inj_count
);

  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int STW  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e                 state_r;
  state_e                 state_nxt_s;
  logic [IDXW-1:0]        rr_ptr_r;
  logic [IDXW-1:0]        rr_nxt_s;
  logic [total_width-1:0] data_r;
  logic [STW-1:0]         stall_r;
  logic [STW-1:0]         stall_nxt_s;
  logic                   starve_r;
  logic [15:0]            inj_cnt_r;

  logic                   xfer_s;
  logic                   can_load_s;
  logic                   grant_any_s;
  logic [IDXW-1:0]        grant_idx_s;
  logic [N_REQ-1:0]       grant_s;
  logic [IDXW:0]          pos_s;
  logic [total_width-1:0] flit_s;

  // A transfer happens whenever a held flit meets switch ready; the output
  // register may take a new flit when it is empty or is emptying this cycle.
  // Reset suppresses grants so no requester is consumed while in reset.
  assign xfer_s     = (state_r == ST_HOLD) & i_ready_pe;
  assign can_load_s = ~rst & ((state_r == ST_IDLE) | xfer_s);

  // Round-robin search: first valid requester at or above rr_ptr_r, wrapping.
  always_comb begin
    grant_any_s = 1'b0;
    grant_idx_s = '0;
    grant_s     = '0;
    pos_s       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      pos_s = {1'b0, rr_ptr_r} + (IDXW+1)'(i);
      if (pos_s >= (IDXW+1)'(N_REQ)) begin
        pos_s = pos_s - (IDXW+1)'(N_REQ);
      end else begin
        pos_s = pos_s;
      end
      if (can_load_s && !grant_any_s && i_valid_req[pos_s[IDXW-1:0]]) begin
        grant_any_s = 1'b1;
        grant_idx_s = pos_s[IDXW-1:0];
      end else begin
        grant_any_s = grant_any_s;
      end
    end
    if (grant_any_s) begin
      grant_s[grant_idx_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  // Build the flit of the granted requester: payload above y above x.
  always_comb begin
    flit_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_idx_s == IDXW'(k)) begin
        flit_s = {i_data_req[k*data_width +: data_width],
                  i_dest_y[k*y_size +: y_size],
                  i_dest_x[k*x_size +: x_size]};
      end else begin
        flit_s = flit_s;
      end
    end
  end

  // Pointer moves just past the winner so it becomes lowest priority next.
  always_comb begin
    if (grant_idx_s == IDXW'(N_REQ - 1)) begin
      rr_nxt_s = '0;
    end else begin
      rr_nxt_s = grant_idx_s + IDXW'(1);
    end
  end

  // Next state: a grant always lands in HOLD; an unreplaced transfer empties.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_any_s) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (grant_any_s) begin
          state_nxt_s = ST_HOLD;
        end else if (i_ready_pe) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Refused-cycle counter: grows only while a held flit is refused, saturating.
  always_comb begin
    if ((state_r == ST_HOLD) && !i_ready_pe) begin
      if (stall_r == STW'(STARVE_LIMIT)) begin
        stall_nxt_s = stall_r;
      end else begin
        stall_nxt_s = stall_r + STW'(1);
      end
    end else begin
      stall_nxt_s = '0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output flit register and round-robin pointer, updated only on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r   <= '0;
      rr_ptr_r <= '0;
    end else if (grant_any_s) begin
      data_r   <= flit_s;
      rr_ptr_r <= rr_nxt_s;
    end else begin
      data_r   <= data_r;
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // Starvation tracking and injected-flit counter (wraps naturally at 16 bits).
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_r   <= '0;
      starve_r  <= 1'b0;
      inj_cnt_r <= 16'h0000;
    end else begin
      stall_r   <= stall_nxt_s;
      starve_r  <= (stall_nxt_s == STW'(STARVE_LIMIT));
      if (xfer_s) begin
        inj_cnt_r <= inj_cnt_r + 16'h0001;
      end else begin
        inj_cnt_r <= inj_cnt_r;
      end
    end
  end

  assign o_ready_req = grant_s;
  assign o_valid_pe  = (state_r == ST_HOLD);
  assign o_data_pe   = data_r;
  assign o_starve    = starve_r;
  assign o_inj_count = inj_cnt_r;

endmodule

// File: tb/tb_noc_pe_inject_arbiter.sv
// Directed, table-driven bench for noc_pe_inject_arbiter (N_REQ=4, 8-bit
// payload, STARVE_LIMIT=4). Requester flits are fixed; expected flits are
// hand-computed constants.
module tb_noc_pe_inject_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int TW  = DW + 2;
  localparam int SL  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   valid_req;
  logic [NR-1:0]   o_ready_req;
  logic [NR*DW-1:0] data_req;
  logic [NR-1:0]   dest_x;
  logic [NR-1:0]   dest_y;
  logic            o_valid_pe;
  logic [TW-1:0]   o_data_pe;
  logic            ready_pe;
  logic            o_starve;
  logic [15:0]     o_inj_count;

  int checks   = 0;
  int failures = 0;

  // Expected flit {payload, y, x} of each requester, computed by hand.
  logic [TW-1:0] exp_flit [NR];

  typedef struct {
    logic [NR-1:0] valid;
    logic          ready;
    logic [NR-1:0] exp_grant;
    logic          exp_valid;
    int            exp_src;
    logic [15:0]   exp_cnt;
  } vec_t;

  vec_t tbl [18];

  noc_pe_inject_arbiter #(
    .N_REQ(NR), .data_width(DW), .x_size(1), .y_size(1),
    .total_width(TW), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst(rst),
    .i_valid_req(valid_req), .o_ready_req(o_ready_req),
    .i_data_req(data_req), .i_dest_x(dest_x), .i_dest_y(dest_y),
    .o_valid_pe(o_valid_pe), .o_data_pe(o_data_pe), .i_ready_pe(ready_pe),
    .o_starve(o_starve), .o_inj_count(o_inj_count)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus and checking.
  initial begin
    // Fixed requester data: payloads 3C,5A,A5,C3; x=0,1,1,0; y=0,1,0,1.
    data_req = {8'hC3, 8'hA5, 8'h5A, 8'h3C};
    dest_x   = 4'b0110;
    dest_y   = 4'b1010;
    exp_flit[0] = 10'h0F0;
    exp_flit[1] = 10'h16B;
    exp_flit[2] = 10'h295;
    exp_flit[3] = 10'h30E;

    tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2, 16'd0};
    tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0, 16'd1};
    tbl[2]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 3, 16'd1};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0, 16'd2};
    tbl[4]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1, 16'd3};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2, 16'd4};
    tbl[6]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3, 16'd5};
    tbl[7]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0, 16'd6};
    tbl[8]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1, 16'd7};
    tbl[9]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2, 16'd8};
    tbl[10] = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3, 16'd9};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0, 16'd10};
    tbl[12] = '{4'b1010, 1'b0, 4'b0010, 1'b1, 1, 16'd10};
    tbl[13] = '{4'b1010, 1'b0, 4'b0000, 1'b1, 1, 16'd10};
    tbl[14] = '{4'b1010, 1'b1, 4'b1000, 1'b1, 3, 16'd11};
    tbl[15] = '{4'b0011, 1'b1, 4'b0001, 1'b1, 0, 16'd12};
    tbl[16] = '{4'b0001, 1'b1, 4'b0001, 1'b1, 0, 16'd13};
    tbl[17] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 0, 16'd14};

    // Reset with all requesters valid: nothing granted, all outputs zero.
    rst = 1'b1; valid_req = 4'b1111; ready_pe = 1'b1;
    #1;
    chk("rst_grant", o_ready_req, 4'b0000);
    tick();
    chk("rst_grant_2", o_ready_req, 4'b0000);
    tick();
    chk("rst_valid", o_valid_pe, 1'b0);
    chk("rst_data", o_data_pe, 10'h000);
    chk("rst_starve", o_starve, 1'b0);
    chk("rst_count", o_inj_count, 16'h0000);
    rst = 1'b0; valid_req = 4'b0000;
    tick();

    // Table: single request, fairness burst, backpressure, wrap search.
    for (int i = 0; i < 18; i++) begin
      valid_req = tbl[i].valid;
      ready_pe  = tbl[i].ready;
      #1;
      chk($sformatf("grant[%0d]", i), o_ready_req, tbl[i].exp_grant);
      tick();
      chk($sformatf("valid[%0d]", i), o_valid_pe, tbl[i].exp_valid);
      if (tbl[i].exp_valid) begin
        chk($sformatf("data[%0d]", i), o_data_pe, exp_flit[tbl[i].exp_src]);
      end
      chk($sformatf("count[%0d]", i), o_inj_count, tbl[i].exp_cnt);
    end

    // Backpressure and starvation: load req2, refuse six cycles, then accept.
    valid_req = 4'b0100; ready_pe = 1'b1;
    #1;
    chk("bp_grant", o_ready_req, 4'b0100);
    tick();
    valid_req = 4'b1111; ready_pe = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      #1;
      chk($sformatf("bp_nogrant[%0d]", j), o_ready_req, 4'b0000);
      tick();
      chk($sformatf("bp_valid[%0d]", j), o_valid_pe, 1'b1);
      chk($sformatf("bp_data[%0d]", j), o_data_pe, exp_flit[2]);
      chk($sformatf("bp_starve[%0d]", j), o_starve, (j >= SL) ? 1'b1 : 1'b0);
    end
    ready_pe = 1'b1;
    #1;
    chk("bp_release_grant", o_ready_req, 4'b1000);
    tick();
    chk("bp_release_data", o_data_pe, exp_flit[3]);
    chk("bp_release_count", o_inj_count, 16'd15);
    chk("bp_release_starve", o_starve, 1'b0);
    valid_req = 4'b0000;
    tick();
    chk("bp_idle_valid", o_valid_pe, 1'b0);
    chk("bp_idle_count", o_inj_count, 16'd16);

    // Reset while holding a refused flit: flit dropped, pointer back to req0.
    valid_req = 4'b0100; ready_pe = 1'b1;
    tick();
    chk("rh_valid", o_valid_pe, 1'b1);
    ready_pe = 1'b0; rst = 1'b1;
    #1;
    chk("rh_grant_in_rst", o_ready_req, 4'b0000);
    tick();
    chk("rh_valid_after", o_valid_pe, 1'b0);
    chk("rh_data_after", o_data_pe, 10'h000);
    chk("rh_count_after", o_inj_count, 16'h0000);
    rst = 1'b0; valid_req = 4'b1111; ready_pe = 1'b1;
    #1;
    chk("rh_rr_restart", o_ready_req, 4'b0001);
    tick();
    chk("rh_data_req0", o_data_pe, exp_flit[0]);

    // Counter wrap: back-to-back req0 transfers from a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0; valid_req = 4'b0001; ready_pe = 1'b1;
    repeat (65536) @(posedge clk);
    #1;
    chk("wrap_ffff", o_inj_count, 16'hFFFF);
    tick();
    chk("wrap_zero", o_inj_count, 16'h0000);
    chk("wrap_valid", o_valid_pe, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
